// File: rtl/timer_ctrl_fsm.sv
// Microwave timer controller: keypad digit capture, run/pause/stop sequencing,
// per-second count enables for the BCD down-counter chain, and completion handling.
module timer_ctrl_fsm #(
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned DONE_CYCLES = 5
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] load_min,
    output logic [3:0] load_sec_tens,
    output logic [3:0] load_sec_ones,
    output logic       loadn,
    output logic       en,
    output logic       counter_clearn,
    output logic       magnetron_on,
    output logic       done,
    output logic [2:0] state
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_RUNNING = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        st;
    state_t        nxt;
    logic [PW-1:0] pre;
    logic [DW-1:0] dcnt;
    logic          key_ok;
    logic          wrap;
    logic          digits_nz;

    assign state = st;

    always_comb begin
        // a key is refused when the shifted-in seconds-tens digit would exceed 5
        key_ok    = key_valid && (key_data <= 4'd9) && (load_sec_ones <= 4'd5)
                    && ((st == S_IDLE) || (st == S_ENTRY));
        wrap      = (pre == PW'(TICK_DIV - 1));
        digits_nz = |{load_min, load_sec_tens, load_sec_ones};
        nxt       = st;
        case (st)
            S_IDLE, S_ENTRY: begin
                if (key_ok)
                    nxt = S_ENTRY;
                else if ((st == S_ENTRY) && start && door_closed && digits_nz)
                    nxt = S_RUNNING;
            end
            S_RUNNING: begin
                if (timer_zero)
                    nxt = S_DONE;
                else if (stop || !door_closed)
                    nxt = S_PAUSED;
            end
            S_PAUSED: begin
                if (stop)
                    nxt = S_IDLE;
                else if (start && door_closed)
                    nxt = S_RUNNING;
            end
            S_DONE: begin
                if (start || stop || (wrap && (dcnt == DW'(DONE_CYCLES - 1))))
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            st             <= S_IDLE;
            load_min       <= '0;
            load_sec_tens  <= '0;
            load_sec_ones  <= '0;
            loadn          <= 1'b1;
            en             <= 1'b0;
            counter_clearn <= 1'b0;
            magnetron_on   <= 1'b0;
            done           <= 1'b0;
            pre            <= '0;
            dcnt           <= '0;
        end else begin
            st             <= nxt;
            loadn          <= !key_ok;
            en             <= 1'b0;
            counter_clearn <= 1'b1;
            magnetron_on   <= (nxt == S_RUNNING);
            done           <= (nxt == S_DONE);
            if (key_ok) begin
                load_min      <= load_sec_tens;
                load_sec_tens <= load_sec_ones;
                load_sec_ones <= key_data;
            end
            case (st)
                S_ENTRY: begin
                    if (nxt == S_RUNNING)
                        pre <= '0;
                end
                S_RUNNING: begin
                    // pausing leaves pre untouched so a resume keeps the tick phase
                    if (nxt == S_RUNNING) begin
                        pre <= wrap ? '0 : pre + 1'b1;
                        en  <= wrap;
                    end else if (nxt == S_DONE) begin
                        pre  <= '0;
                        dcnt <= '0;
                    end
                end
                S_PAUSED: begin
                    if (nxt == S_IDLE) begin
                        load_min       <= '0;
                        load_sec_tens  <= '0;
                        load_sec_ones  <= '0;
                        counter_clearn <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (nxt == S_IDLE) begin
                        load_min      <= '0;
                        load_sec_tens <= '0;
                        load_sec_ones <= '0;
                    end else begin
                        pre <= wrap ? '0 : pre + 1'b1;
                        if (wrap)
                            dcnt <= dcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Bench for timer_ctrl_fsm: directed scenarios then random stimulus, all checked
// every cycle against a behavioural model tracking the entered time as a decimal number.
module tb_timer_ctrl_fsm;

    localparam int TD = 4;
    localparam int DC = 2;

    logic       clock = 1'b0;
    logic       clear, key_valid, start, stop, door_closed, timer_zero;
    logic [3:0] key_data;
    logic [3:0] load_min, load_sec_tens, load_sec_ones;
    logic       loadn, en, counter_clearn, magnetron_on, done;
    logic [2:0] state;

    timer_ctrl_fsm #(.TICK_DIV(TD), .DONE_CYCLES(DC)) dut (
        .clock(clock), .clear(clear), .key_valid(key_valid), .key_data(key_data),
        .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .load_min(load_min), .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
        .loadn(loadn), .en(en), .counter_clearn(counter_clearn),
        .magnetron_on(magnetron_on), .done(done), .state(state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    // model: mode number, entered time as min*100+tens*10+ones, cycles run, done cycles left
    int m_state = 0, m_entry = 0, m_phase = 0, m_left = 0;
    int e_loadn = 1, e_en = 0, e_clrn = 0;
    int loadn_count = 0, en_count = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        e_loadn = 1;
        e_en    = 0;
        e_clrn  = 1;
        if (clear) begin
            m_state = 0; m_entry = 0; m_phase = 0; m_left = 0; e_clrn = 0;
        end else begin
            case (m_state)
                0, 1: begin
                    if (key_valid && key_data <= 9 && (m_entry % 10) <= 5) begin
                        m_entry = (m_entry % 100) * 10 + int'(key_data);
                        m_state = 1;
                        e_loadn = 0;
                    end else if (m_state == 1 && start && door_closed && m_entry != 0) begin
                        m_state = 2;
                        m_phase = 0;
                    end
                end
                2: begin
                    if (timer_zero) begin
                        m_state = 4;
                        m_left  = TD * DC;
                    end else if (stop || !door_closed) begin
                        m_state = 3;
                    end else begin
                        m_phase++;
                        if (m_phase == TD) begin
                            m_phase = 0;
                            e_en    = 1;
                        end
                    end
                end
                3: begin
                    if (stop) begin
                        m_state = 0; m_entry = 0; e_clrn = 0;
                    end else if (start && door_closed) begin
                        m_state = 2;
                    end
                end
                4: begin
                    m_left--;
                    if (start || stop || m_left == 0) begin
                        m_state = 0; m_entry = 0;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        check("state", int'(state), m_state);
        check("load_min", int'(load_min), m_entry / 100);
        check("load_sec_tens", int'(load_sec_tens), (m_entry / 10) % 10);
        check("load_sec_ones", int'(load_sec_ones), m_entry % 10);
        check("loadn", int'(loadn), e_loadn);
        check("en", int'(en), e_en);
        check("counter_clearn", int'(counter_clearn), e_clrn);
        check("magnetron_on", int'(magnetron_on), int'(m_state == 2));
        check("done", int'(done), int'(m_state == 4));
        check("loadn_en_exclusive", int'(!loadn && en), 0);
        loadn_count += int'(!loadn);
        en_count    += int'(en);
    endtask

    task automatic key(input int d);
        key_valid = 1'b1;
        key_data  = 4'(d);
        step();
        key_valid = 1'b0;
        step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_phase(input int cycles, input int p_start, input int p_stop, input int p_tz);
        for (int i = 0; i < cycles; i++) begin
            clear       = ($urandom_range(199) == 0);
            key_valid   = ($urandom_range(3) == 0);
            key_data    = 4'($urandom_range(11));
            start       = ($urandom_range(p_start - 1) == 0);
            stop        = ($urandom_range(p_stop - 1) == 0);
            door_closed = ($urandom_range(15) != 0);
            timer_zero  = ($urandom_range(p_tz - 1) == 0);
            step();
        end
    endtask

    initial begin
        int dcount;
        clear = 1'b1; key_valid = 1'b0; key_data = '0; start = 1'b0; stop = 1'b0;
        door_closed = 1'b1; timer_zero = 1'b0;
        steps(2);
        check("rst_clearn_low", int'(counter_clearn), 0);
        clear = 1'b0;
        step();
        check("clearn_release", int'(counter_clearn), 1);

        loadn_count = 0;
        key(1); key(3); key(0);
        check("keys130_pulses", loadn_count, 3);
        check("keys130_min", int'(load_min), 1);
        check("keys130_tens", int'(load_sec_tens), 3);
        check("keys130_state", int'(state), 1);

        door_closed = 1'b0; start = 1'b1;
        steps(2);
        check("door_open_start", int'(state), 1);
        door_closed = 1'b1;
        step();
        start = 1'b0;
        check("run_state", int'(state), 2);
        en_count = 0;
        steps(12);
        check("run_en_count", en_count, 3);

        steps(2);
        stop = 1'b1; step(); stop = 1'b0;
        check("pause_state", int'(state), 3);
        en_count = 0;
        steps(8);
        check("pause_en_silent", en_count, 0);
        start = 1'b1; step(); start = 1'b0;
        steps(9);
        stop = 1'b1; step();
        step();
        stop = 1'b0;
        check("cancel_state", int'(state), 0);
        check("cancel_clearn", int'(counter_clearn), 0);
        check("cancel_digits", int'({load_min, load_sec_tens, load_sec_ones}), 0);
        step();

        loadn_count = 0;
        key(7); key(9);
        check("keys79_pulses", loadn_count, 1);
        check("keys79_ones", int'(load_sec_ones), 7);
        check("keys79_tens", int'(load_sec_tens), 0);

        start = 1'b1; step(); start = 1'b0;
        steps(5);
        timer_zero = 1'b1; step(); timer_zero = 1'b0;
        check("tz_done_state", int'(state), 4);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dcount++;
            if (state == 3'd0) break;
            step();
        end
        check("done_cycles", dcount, TD * DC);
        check("done_exit_state", int'(state), 0);

        key(2); key(5);
        start = 1'b1; step(); start = 1'b0;
        steps(6);
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_run_state", int'(state), 0);
        check("clear_run_mag", int'(magnetron_on), 0);
        check("clear_run_clearn", int'(counter_clearn), 0);
        step();

        rand_phase(800, 3, 20, 60);
        rand_phase(800, 30, 30, 20);
        rand_phase(800, 2, 200, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
